// File: rtl/mcu_spi_frame_rx.sv
// SPI mode-0 slave frame receiver: synchronises SCK/MOSI/NSS into CLK, deserialises one
// FRAME_BITS frame per NSS assertion and shifts a preloaded response out on MISO.
// Optional build macro MCU_SPI_MISO_HIZ_EN: MISO floats outside frames for shared-bus use.
module mcu_spi_frame_rx #(
    parameter int FRAME_BITS = 64
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  MCU_SPI_SCK,
    input  logic                  MCU_SPI_MOSI,
    input  logic                  MCU_SPI_NSS,
    output logic                  MCU_SPI_MISO,
    input  logic [FRAME_BITS-1:0] tx_data,
    input  logic                  tx_load,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_error,
    output logic                  busy
);

    localparam int CW = $clog2(FRAME_BITS + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
    localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_BITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e state_q, state_d;

    // [0],[1] form the synchroniser, [2] is the edge-detect history
    logic [2:0] sck_q, mosi_q, nss_q;

    logic [FRAME_BITS-1:0] shadow_q, tx_sr_q, rx_sr_q, rx_data_q;
    logic [CW-1:0]         cnt_q;
    logic                  miso_q, rx_valid_q, rx_error_q;

    logic sck_rise, sck_fall, nss_fall, nss_rise;
    logic start, rx_shift, tx_shift, frame_end;
    logic [FRAME_BITS-1:0] tx_word;

    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign nss_fall = ~nss_q[1] & nss_q[2];
    assign nss_rise = nss_q[1] & ~nss_q[2];

    // A load in the same cycle as frame start goes straight into the TX shifter
    assign tx_word = tx_load ? tx_data : shadow_q;

    // NSS chain resets low so a frame needs NSS to be seen high before it can fall
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sck_q  <= '0;
            mosi_q <= '0;
            nss_q  <= '0;
        end else begin
            sck_q  <= {sck_q[1:0], MCU_SPI_SCK};
            mosi_q <= {mosi_q[1:0], MCU_SPI_MOSI};
            nss_q  <= {nss_q[1:0], MCU_SPI_NSS};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        rx_shift  = 1'b0;
        tx_shift  = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            IDLE: begin
                if (nss_fall) begin
                    start   = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (nss_rise) begin
                    state_d = DONE;
                end else begin
                    rx_shift = sck_rise;
                    tx_shift = sck_fall;
                end
            end
            DONE: begin
                frame_end = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shadow_q   <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            cnt_q      <= '0;
            miso_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_error_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_error_q <= 1'b0;
            if (tx_load) shadow_q <= tx_data;
            if (start) begin
                tx_sr_q <= tx_word;
                miso_q  <= tx_word[FRAME_BITS-1];
                rx_sr_q <= '0;
                cnt_q   <= '0;
            end
            // History-stage MOSI lines up with the SCK sample taken just before the rise
            if (rx_shift) begin
                rx_sr_q <= {rx_sr_q[FRAME_BITS-2:0], mosi_q[2]};
                if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
            end
            if (tx_shift) begin
                tx_sr_q <= tx_sr_q << 1;
                miso_q  <= tx_sr_q[FRAME_BITS-2];
            end
            if (frame_end) begin
                miso_q <= 1'b0;
                if (cnt_q == CNT_FULL) begin
                    rx_data_q  <= rx_sr_q;
                    rx_valid_q <= 1'b1;
                end else begin
                    rx_error_q <= 1'b1;
                end
            end
        end
    end

`ifdef MCU_SPI_MISO_HIZ_EN
    assign MCU_SPI_MISO = (state_q == SHIFT) ? miso_q : 1'bz;
`else
    assign MCU_SPI_MISO = miso_q;
`endif

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_error = rx_error_q;
    assign busy     = (state_q == SHIFT);

endmodule

// File: tb/tb_mcu_spi_frame_rx.sv
// Directed self-checking bench for mcu_spi_frame_rx: good/short/long/empty frames,
// MISO latency, mid-frame tx_load and reset mid-frame.
module tb_mcu_spi_frame_rx;

    localparam int FB = 64;
`ifdef MCU_SPI_MISO_HIZ_EN
    localparam logic MISO_IDLE = 1'bz;
`else
    localparam logic MISO_IDLE = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST_N, sck, mosi, nss, tx_load;
    logic [FB-1:0] tx_data, rx_data;
    wire           miso;
    logic          rx_valid, rx_error, busy;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mcu_spi_frame_rx #(.FRAME_BITS(FB)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .MCU_SPI_SCK(sck), .MCU_SPI_MOSI(mosi), .MCU_SPI_NSS(nss), .MCU_SPI_MISO(miso),
        .tx_data(tx_data), .tx_load(tx_load),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error), .busy(busy)
    );

    task automatic load_tx(input logic [FB-1:0] w);
        @(negedge CLK);
        tx_data = w; tx_load = 1'b1;
        @(negedge CLK);
        tx_load = 1'b0;
    endtask

    // SCK = CLK/8; MISO captured just before each SCK rise. Returns early with RST_N low at rst_at.
    task automatic spi_frame(input logic [127:0] d, input int nbits, input int load_at,
                             input int rst_at, output logic [127:0] mrd);
        mrd = '0;
        nss = 1'b0;
        repeat (4) @(negedge CLK);
        for (int b = 0; b < nbits; b++) begin
            mosi = d[nbits-1-b];
            if (b == load_at) begin
                tx_data = '1; tx_load = 1'b1;
                @(negedge CLK);
                tx_load = 1'b0;
                repeat (3) @(negedge CLK);
            end else begin
                repeat (4) @(negedge CLK);
            end
            if (b == rst_at) begin
                RST_N = 1'b0;
                return;
            end
            mrd = {mrd[126:0], miso};
            sck = 1'b1;
            repeat (4) @(negedge CLK);
            sck = 1'b0;
        end
        repeat (4) @(negedge CLK);
        nss = 1'b1;
    endtask

    // Called right after NSS rises; edge 1 is the first CLK edge that samples it high
    task automatic end_wait(output int lat_v, output int nv, output int ne);
        lat_v = -1; nv = 0; ne = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge CLK); #1;
            if (rx_valid === 1'b1) begin
                nv++;
                if (lat_v < 0) lat_v = i;
            end
            if (rx_error === 1'b1) ne++;
        end
    endtask

    task automatic test_reset();
        checks++; if (rx_data !== '0) begin errors++; $display("FAIL reset_rx_data got %h want 0", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
        checks++; if (rx_error !== 1'b0) begin errors++; $display("FAIL reset_rx_error got %b want 0", rx_error); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (miso !== MISO_IDLE) begin errors++; $display("FAIL reset_miso got %b want %b", miso, MISO_IDLE); end
    endtask

    task automatic test_good_frame();
        logic [127:0] mrd;
        int lat, nv, ne;
        load_tx(64'hA5A5_0F0F_1234_5678);
        spi_frame({64'h0, 64'hDEAD_BEEF_CAFE_0001}, 64, -1, -1, mrd);
        end_wait(lat, nv, ne);
        checks++; if (nv != 1) begin errors++; $display("FAIL good_valid_count got %0d want 1", nv); end
        checks++; if (lat != 4) begin errors++; $display("FAIL good_valid_latency got %0d want 4", lat); end
        checks++; if (ne != 0) begin errors++; $display("FAIL good_error_count got %0d want 0", ne); end
        checks++; if (rx_data !== 64'hDEAD_BEEF_CAFE_0001) begin errors++; $display("FAIL good_rx_data got %h want deadbeefcafe0001", rx_data); end
        checks++; if (mrd[63:0] !== 64'hA5A5_0F0F_1234_5678) begin errors++; $display("FAIL good_miso_word got %h want a5a50f0f12345678", mrd[63:0]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy_after got %b want 0", busy); end
    endtask

    task automatic test_miso_latency();
        int lat, nv, ne;
        load_tx(64'h8000_0000_0000_0000);
        @(negedge CLK);
        nss = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        checks++; if (miso !== MISO_IDLE) begin errors++; $display("FAIL lat_miso_edge2 got %b want %b", miso, MISO_IDLE); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lat_busy_edge2 got %b want 0", busy); end
        @(posedge CLK); #1;
        checks++; if (miso !== 1'b1) begin errors++; $display("FAIL lat_miso_edge3 got %b want 1", miso); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lat_busy_edge3 got %b want 1", busy); end
        @(negedge CLK);
        nss = 1'b1;
        end_wait(lat, nv, ne);
        checks++; if (ne != 1 || nv != 0) begin errors++; $display("FAIL lat_zero_bit_frame got err=%0d val=%0d want err=1 val=0", ne, nv); end
    endtask

    task automatic test_short_long_empty();
        logic [127:0] mrd;
        int lat, nv, ne;
        spi_frame({64'h0, 64'h1234_5678_9ABC_DEF0}, 63, -1, -1, mrd);
        end_wait(lat, nv, ne);
        checks++; if (ne != 1 || nv != 0) begin errors++; $display("FAIL short_strobes got err=%0d val=%0d want err=1 val=0", ne, nv); end
        checks++; if (rx_data !== 64'hDEAD_BEEF_CAFE_0001) begin errors++; $display("FAIL short_rx_hold got %h want deadbeefcafe0001", rx_data); end
        spi_frame({63'h0, 1'b1, 64'h0F0F_0F0F_F0F0_F0F0}, 65, -1, -1, mrd);
        end_wait(lat, nv, ne);
        checks++; if (ne != 1 || nv != 0) begin errors++; $display("FAIL long_strobes got err=%0d val=%0d want err=1 val=0", ne, nv); end
        checks++; if (rx_data !== 64'hDEAD_BEEF_CAFE_0001) begin errors++; $display("FAIL long_rx_hold got %h want deadbeefcafe0001", rx_data); end
        @(negedge CLK);
        nss = 1'b0;
        repeat (10) @(negedge CLK);
        nss = 1'b1;
        end_wait(lat, nv, ne);
        checks++; if (ne != 1 || nv != 0) begin errors++; $display("FAIL empty_strobes got err=%0d val=%0d want err=1 val=0", ne, nv); end
    endtask

    task automatic test_mid_load();
        logic [127:0] mrd;
        int lat, nv, ne;
        load_tx(64'h0123_4567_89AB_CDEF);
        spi_frame({64'h0, 64'h5555_AAAA_5555_AAAA}, 64, 20, -1, mrd);
        end_wait(lat, nv, ne);
        checks++; if (mrd[63:0] !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL midload_cur_miso got %h want 0123456789abcdef", mrd[63:0]); end
        checks++; if (nv != 1 || rx_data !== 64'h5555_AAAA_5555_AAAA) begin errors++; $display("FAIL midload_rx got val=%0d data=%h want val=1 data=5555aaaa5555aaaa", nv, rx_data); end
        spi_frame({64'h0, 64'h0F0F_1E1E_2D2D_3C3C}, 64, -1, -1, mrd);
        end_wait(lat, nv, ne);
        checks++; if (mrd[63:0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL midload_next_miso got %h want ffffffffffffffff", mrd[63:0]); end
        checks++; if (nv != 1 || rx_data !== 64'h0F0F_1E1E_2D2D_3C3C) begin errors++; $display("FAIL back_to_back_rx got val=%0d data=%h want val=1 data=0f0f1e1e2d2d3c3c", nv, rx_data); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] mrd;
        int lat, nv, ne;
        spi_frame({64'h0, 64'hFEDC_BA98_7654_3210}, 64, -1, 30, mrd);
        repeat (2) @(negedge CLK);
        checks++; if (rx_data !== '0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_state got data=%h busy=%b want 0/0", rx_data, busy); end
        checks++; if (rx_valid !== 1'b0 || rx_error !== 1'b0) begin errors++; $display("FAIL rstmid_strobes got val=%b err=%b want 0/0", rx_valid, rx_error); end
        checks++; if (miso !== MISO_IDLE) begin errors++; $display("FAIL rstmid_miso got %b want %b", miso, MISO_IDLE); end
        RST_N = 1'b1;
        repeat (10) @(negedge CLK);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nss_low_release_busy got %b want 0", busy); end
        nss = 1'b1;
        end_wait(lat, nv, ne);
        checks++; if (nv != 0 || ne != 0) begin errors++; $display("FAIL nss_low_release_strobes got val=%0d err=%0d want 0/0", nv, ne); end
        spi_frame({64'h0, 64'h0000_0000_0000_0001}, 64, -1, -1, mrd);
        end_wait(lat, nv, ne);
        checks++; if (nv != 1 || rx_data !== 64'h1) begin errors++; $display("FAIL rstmid_next_rx got val=%0d data=%h want val=1 data=1", nv, rx_data); end
        checks++; if (mrd[63:0] !== 64'h0) begin errors++; $display("FAIL rstmid_shadow_cleared got %h want 0", mrd[63:0]); end
    endtask

    initial begin
        RST_N = 1'b0; sck = 1'b0; mosi = 1'b0; nss = 1'b1;
        tx_load = 1'b0; tx_data = '0;
        repeat (4) @(negedge CLK);
        test_reset();
        RST_N = 1'b1;
        repeat (4) @(negedge CLK);
        test_good_frame();
        test_miso_latency();
        test_short_long_empty();
        test_mid_load();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
